ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 75 +++++++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared defaults, FSM state type and port identifiers for the RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter with lock-based ownership.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_own_i,
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic a_lock_i,
  input  logic b_lock_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  logic own_v_q, own_v_d;
  logic own_q, own_d;
  logic last_q, last_d;
  logic own_lock;
  logic hold;

  always_comb begin
    own_lock = (own_q == PORT_A) ? a_lock_i : b_lock_i;
    hold     = own_v_q && own_lock;

    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (en_i) begin
      if (hold) begin
        // a locked owner blocks the other port even when it is not requesting
        if (own_q == PORT_A) a_gnt_o = a_req_i;
        else                 b_gnt_o = b_req_i;
      end else if (a_req_i && b_req_i) begin
        if (last_q == PORT_A) b_gnt_o = 1'b1;
        else                  a_gnt_o = 1'b1;
      end else begin
        a_gnt_o = a_req_i;
        b_gnt_o = b_req_i;
      end
    end

    own_v_d = hold;
    own_d   = own_q;
    last_d  = last_q;
    if (a_gnt_o) begin
      last_d = PORT_A;
      if (a_lock_i) begin
        own_v_d = 1'b1;
        own_d   = PORT_A;
      end
    end
    if (b_gnt_o) begin
      last_d = PORT_B;
      if (b_lock_i) begin
        own_v_d = 1'b1;
        own_d   = PORT_B;
      end
    end
    if (clr_own_i) own_v_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_v_q <= 1'b0;
      own_q   <= PORT_A;
      last_q  <= PORT_B;
    end else begin
      own_v_q <= own_v_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter with a full-RAM clear sweep.
// state    | meaning
// ST_IDLE  | arbitrate port A/B accesses onto the RAM
// ST_CLEAR | write 0 to every address, ascending, one per cycle
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              a_lock_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic              b_lock_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              arb_en, clr_own;
  logic              a_rd, b_rd;

  // reset gates the grants so nothing reaches the RAM while rst_ni is low
  assign arb_en  = rst_ni && (state_q == ST_IDLE) && !clr_i;
  assign clr_own = (state_q == ST_IDLE) && clr_i;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (arb_en),
    .clr_own_i (clr_own),
    .a_req_i   (a_req_i),
    .b_req_i   (b_req_i),
    .a_lock_i  (a_lock_i),
    .b_lock_i  (b_lock_i),
    .a_gnt_o   (a_gnt_o),
    .b_gnt_o   (b_gnt_o)
  );

  assign a_rd = a_gnt_o && !a_we_i;
  assign b_rd = b_gnt_o && !b_we_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    busy_o     = 1'b0;
    ram_wen_o  = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (a_gnt_o) begin
          ram_wen_o  = a_we_i;
          ram_addr_o = a_addr_i;
          ram_din_o  = a_wdata_i;
        end else if (b_gnt_o) begin
          ram_wen_o  = b_we_i;
          ram_addr_o = b_addr_i;
          ram_din_o  = b_wdata_i;
        end
      end
      ST_CLEAR: begin
        busy_o     = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = cnt_q;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      if (a_rd) a_rdata_q <= ram_dout_i;
      if (b_rd) b_rdata_q <= ram_dout_i;
    end
  end

  assign done_o     = done_q;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock, clr;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       busy, done, ram_wen;
  logic [4:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [32];
  logic [7:0] exp_mem [32];
  logic       preload_en, preload_pat;
  logic [7:0] preload_val;

  logic [7:0] a_q [$];
  logic [7:0] b_q [$];
  logic       a_pend, b_pend;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .a_req_i    (a_req),
    .a_we_i     (a_we),
    .a_addr_i   (a_addr),
    .a_wdata_i  (a_wdata),
    .a_lock_i   (a_lock),
    .a_gnt_o    (a_gnt),
    .a_rvalid_o (a_rvalid),
    .a_rdata_o  (a_rdata),
    .b_req_i    (b_req),
    .b_we_i     (b_we),
    .b_addr_i   (b_addr),
    .b_wdata_i  (b_wdata),
    .b_lock_i   (b_lock),
    .b_gnt_o    (b_gnt),
    .b_rvalid_o (b_rvalid),
    .b_rdata_o  (b_rdata),
    .clr_i      (clr),
    .busy_o     (busy),
    .done_o     (done),
    .ram_wen_o  (ram_wen),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= preload_pat ? 8'(i * 7 + 1) : preload_val;
    end else if (ram_wen) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: a granted read pushes the modelled word, rvalid pops it next cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
      b_q.delete();
      a_pend = 1'b0;
      b_pend = 1'b0;
    end else begin
      chk("a_rvalid", 32'(a_rvalid), 32'(a_pend));
      if (a_rvalid && a_q.size() > 0) chk("a_rdata", 32'(a_rdata), 32'(a_q.pop_front()));
      chk("b_rvalid", 32'(b_rvalid), 32'(b_pend));
      if (b_rvalid && b_q.size() > 0) chk("b_rdata", 32'(b_rdata), 32'(b_q.pop_front()));
      chk("gnt_excl", 32'(a_gnt & b_gnt), 32'd0);
      a_pend = a_gnt && !a_we;
      b_pend = b_gnt && !b_we;
      if (a_pend) a_q.push_back(exp_mem[a_addr]);
      if (b_pend) b_q.push_back(exp_mem[b_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] val);
    preload_val = val;
    preload_pat = 1'b0;
    preload_en  = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = val;
    tick();
    preload_en = 1'b0;
  endtask

  task automatic a_read(input logic [4:0] addr);
    a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    tick();
    a_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_lock = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_lock = 1'b0;
    preload_en = 1'b1; preload_pat = 1'b1; preload_val = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'(i * 7 + 1);

    // reset state with both ports requesting
    @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_wen", 32'(ram_wen), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    preload_en = 1'b0; a_req = 1'b0; b_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // write 0x5A @3 then read it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 8'h5A;
    exp_mem[3] = 8'h5A;
    @(negedge clk);
    chk("wr_gnt", 32'(a_gnt), 1);
    chk("wr_wen", 32'(ram_wen), 1);
    chk("wr_addr", 32'(ram_addr), 3);
    chk("wr_din", 32'(ram_din), 32'h5A);
    tick();
    a_we = 1'b0; a_wdata = '0;
    @(negedge clk);
    chk("rd_gnt", 32'(a_gnt), 1);
    chk("rd_wen", 32'(ram_wen), 0);
    tick();
    a_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(a_rvalid), 1);
    chk("rd_rdata", 32'(a_rdata), 32'h5A);
    chk("idle_bus", 32'({ram_wen, ram_addr, ram_din}), 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_once", 32'(a_rvalid), 0);
    chk("rd_rdata_hold", 32'(a_rdata), 32'h5A);

    // round-robin from reset: A,B,A,B,...
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_req = 1'b1; a_addr = 5'd3; b_req = 1'b1; b_addr = 5'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_a_gnt", 32'(a_gnt), 32'(k % 2 == 0));
      chk("rr_b_gnt", 32'(b_gnt), 32'(k % 2 == 1));
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;

    // lock: A alone first so B wins the next contention and locks
    a_req = 1'b1; a_addr = 5'd1;
    @(negedge clk);
    chk("solo_a_gnt", 32'(a_gnt), 1);
    tick();
    b_req = 1'b1; b_lock = 1'b1; b_addr = 5'd5;
    @(negedge clk);
    chk("lk0_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    tick();
    @(negedge clk);
    chk("lk1_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    tick();
    b_req = 1'b0;
    @(negedge clk);
    chk("lk2_gnt", 32'({a_gnt, b_gnt}), 32'b00);
    tick();
    b_lock = 1'b0; b_req = 1'b1;
    @(negedge clk);
    chk("lk_rel_gnt", 32'({a_gnt, b_gnt}), 32'b10);
    tick();
    a_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("solo_b_gnt", 32'(b_gnt), 1);
      tick();
    end
    b_req = 1'b0;
    tick();

    // full clear over a 0xFF-filled RAM, clr beats a locked request
    preload(8'hFF);
    clr = 1'b1; a_req = 1'b1; a_lock = 1'b1; a_addr = 5'd2;
    @(negedge clk);
    chk("clr_pri_gnt", 32'(a_gnt), 0);
    chk("clr_pri_busy", 32'(busy), 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      clr = (i == 5);
      @(negedge clk);
      chk("clr_busy", 32'(busy), 1);
      chk("clr_wen", 32'(ram_wen), 1);
      chk("clr_addr", 32'(ram_addr), 32'(i));
      chk("clr_din", 32'(ram_din), 0);
      chk("clr_gnt", 32'({a_gnt, b_gnt}), 0);
      exp_mem[i] = 8'h00;
      tick();
    end
    clr = 1'b0; a_req = 1'b0; a_lock = 1'b0;
    @(negedge clk);
    chk("clr_done", 32'(done), 1);
    chk("clr_done_busy", 32'(busy), 0);
    chk("clr_done_wen", 32'(ram_wen), 0);
    tick();
    @(negedge clk);
    chk("clr_done_pulse", 32'(done), 0);
    a_read(5'd0);
    a_read(5'd31);
    @(negedge clk);
    chk("clr_rd31", 32'(a_rdata), 0);
    tick();

    // reset in clear cycle 10 aborts the sweep
    preload(8'hFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_mem[i] = 8'h00;
      tick();
    end
    @(negedge clk);
    chk("abort_addr", 32'(ram_addr), 10);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bus", 32'({ram_wen, ram_addr, ram_din}), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done, busy}), 0);
      tick();
    end
    a_read(5'd0);
    a_read(5'd9);
    a_read(5'd10);
    a_read(5'd20);
    @(negedge clk);
    chk("abort_rd20", 32'(a_rdata), 32'hFF);
    tick();
    tick();

    chk("a_q_empty", 32'(a_q.size()), 0);
    chk("b_q_empty", 32'(b_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
